// File: rtl/uc_pkg.sv
// Shared opcode encodings, mux-select constants and FSM state type for the uc_int control unit.
package uc_pkg;

   localparam logic [5:0] OP_JMP     = 6'b100100;
   localparam logic [5:0] OP_JZ      = 6'b100101;
   localparam logic [5:0] OP_JNZ     = 6'b100110;
   localparam logic [5:0] OP_RET     = 6'b101000;
   localparam logic [5:0] OP_CALL    = 6'b101001;
   localparam logic [5:0] OP_IN      = 6'b101010;
   localparam logic [5:0] OP_OUT_REG = 6'b101011;
   localparam logic [5:0] OP_OUT_INM = 6'b101100;
   localparam logic [5:0] OP_RETI    = 6'b101101;
   localparam logic [5:0] OP_EI      = 6'b101110;
   localparam logic [5:0] OP_DI      = 6'b101111;

   localparam logic [1:0] SINM_ALU = 2'b00;
   localparam logic [1:0] SINM_IMM = 2'b01;
   localparam logic [1:0] SINM_MEM = 2'b10;
   localparam logic [1:0] SINM_IN  = 2'b11;

   localparam logic [1:0] SOUT_REG = 2'b00;
   localparam logic [1:0] SOUT_INM = 2'b01;

   typedef enum logic [1:0] {RUN, INT_PUSH, INT_VEC} state_t;

   // Index width for NINT lines; a single line still needs one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uc_int_prio.sv
// Fixed-priority interrupt selector: lowest-index pending line wins.
module uc_int_prio
   import uc_pkg::*;
#(
   parameter int unsigned NINT = 2,
   parameter int unsigned IDW  = id_width(NINT)
) (
   input  logic [NINT-1:0] pending,
   output logic            valid,
   output logic [IDW-1:0]  id,
   output logic [NINT-1:0] onehot
);

   // Scan from the top down so the lowest set index is written last.
   always_comb begin
      valid  = 1'b0;
      id     = '0;
      onehot = '0;
      for (int i = int'(NINT) - 1; i >= 0; i--) begin
         if (pending[i]) begin
            valid     = 1'b1;
            id        = IDW'(i);
            onehot    = '0;
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uc_int.sv
// Single-cycle CPU control unit with opcode decode and an edge-triggered interrupt entry engine.
// Define INTR_SYNC_EN to pass each intr line through a 2-flop synchroniser before edge detection.
module uc_int
   import uc_pkg::*;
#(
   parameter int unsigned NINT       = 2,
   parameter int unsigned PCW        = 10,
   parameter int unsigned VEC_BASE   = 1008,
   parameter int unsigned VEC_STRIDE = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [5:0]      opcode,
   input  logic [1:0]      io_sel,
   input  logic            z,
   input  logic [NINT-1:0] intr,
   output logic            s_inc,
   output logic            we3,
   output logic            wez,
   output logic            pop,
   output logic            push,
   output logic            s_stack,
   output logic            we4,
   output logic            we_out,
   output logic [1:0]      s_inm,
   output logic [1:0]      s_in,
   output logic [1:0]      s_out,
   output logic [2:0]      op_alu,
   output logic            s_vec,
   output logic [PCW-1:0]  vec_addr,
   output logic [NINT-1:0] int_ack,
   output logic            ie
);

   localparam int unsigned IDW = id_width(NINT);

   state_t          state_q, state_d;
   logic            ie_q, ie_d;
   logic [NINT-1:0] pend_q, pend_d;
   logic [NINT-1:0] intr_s, intr_q, rise;
   logic [IDW-1:0]  id_q, id_d;
   logic [NINT-1:0] sel_q, sel_d;
   logic            pvalid;
   logic [IDW-1:0]  pid;
   logic [NINT-1:0] ponehot;
   logic            take;

`ifdef INTR_SYNC_EN
   logic [NINT-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= intr;
         sync2_q <= sync1_q;
      end
   end

   assign intr_s = sync2_q;
`else
   assign intr_s = intr;
`endif

   assign rise = intr_s & ~intr_q;

   uc_int_prio #(
      .NINT (NINT),
      .IDW  (IDW)
   ) u_prio (
      .pending (pend_q),
      .valid   (pvalid),
      .id      (pid),
      .onehot  (ponehot)
   );

   assign take     = (state_q == RUN) && ie_q && pvalid;
   assign int_ack  = (state_q == INT_VEC) ? sel_q : '0;
   // A fresh edge on the line being acknowledged survives the clear.
   assign pend_d   = (pend_q & ~int_ack) | rise;
   assign vec_addr = PCW'(VEC_BASE + 32'(id_q) * VEC_STRIDE);
   assign ie       = ie_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         ie_q    <= 1'b0;
         pend_q  <= '0;
         intr_q  <= '0;
         id_q    <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         ie_q    <= ie_d;
         pend_q  <= pend_d;
         intr_q  <= intr_s;
         id_q    <= id_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ie_d    = ie_q;
      id_d    = id_q;
      sel_d   = sel_q;
      s_inc   = 1'b0;
      we3     = 1'b0;
      wez     = 1'b0;
      pop     = 1'b0;
      push    = 1'b0;
      s_stack = 1'b0;
      we4     = 1'b0;
      we_out  = 1'b0;
      s_inm   = SINM_ALU;
      s_in    = 2'b00;
      s_out   = SOUT_REG;
      op_alu  = 3'b000;
      s_vec   = 1'b0;

      unique case (state_q)
         RUN: begin
            if (take) begin
               // Squash: every output stays at its default, PC holds.
               state_d = INT_PUSH;
               ie_d    = 1'b0;
               id_d    = pid;
               sel_d   = ponehot;
            end else begin
               s_inc = 1'b1;
               casez (opcode)
                  6'b0?????: begin
                     we3    = 1'b1;
                     wez    = 1'b1;
                     op_alu = opcode[4:2];
                  end
                  6'b1000??: begin
                     we3   = 1'b1;
                     s_inm = SINM_IMM;
                  end
                  OP_JMP:  s_inc = 1'b0;
                  OP_JZ:   s_inc = ~z;
                  OP_JNZ:  s_inc = z;
                  OP_RET: begin
                     s_inc   = 1'b0;
                     pop     = 1'b1;
                     s_stack = 1'b1;
                  end
                  OP_RETI: begin
                     s_inc   = 1'b0;
                     pop     = 1'b1;
                     s_stack = 1'b1;
                     ie_d    = 1'b1;
                  end
                  OP_CALL: push = 1'b1;
                  OP_IN: begin
                     we3   = 1'b1;
                     s_inm = SINM_IN;
                     s_in  = io_sel;
                  end
                  OP_OUT_REG: begin
                     we_out = 1'b1;
                     s_out  = SOUT_REG;
                  end
                  OP_OUT_INM: begin
                     we_out = 1'b1;
                     s_out  = SOUT_INM;
                  end
                  OP_EI: ie_d = 1'b1;
                  OP_DI: ie_d = 1'b0;
                  6'b1110??: we4 = 1'b1;
                  6'b1111??: begin
                     we3   = 1'b1;
                     s_inm = SINM_MEM;
                  end
                  default: ;
               endcase
            end
         end
         INT_PUSH: begin
            push    = 1'b1;
            state_d = INT_VEC;
         end
         INT_VEC: begin
            s_vec   = 1'b1;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

endmodule

// File: tb/tb_uc_int.sv
// Self-checking bench for uc_int: directed interrupt scenarios plus randomized traffic vs a reference model.
module tb_uc_int;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [1:0] io_sel;
   logic       z;
   logic [1:0] intr;
   logic       s_inc, we3, wez, pop, push, s_stack, we4, we_out, s_vec, ie;
   logic [1:0] s_inm, s_in, s_out, int_ack;
   logic [2:0] op_alu;
   logic [9:0] vec_addr;

   int n_checks = 0;
   int n_fail   = 0;

   uc_int #(
      .NINT       (2),
      .PCW        (10),
      .VEC_BASE   (1008),
      .VEC_STRIDE (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .opcode   (opcode),
      .io_sel   (io_sel),
      .z        (z),
      .intr     (intr),
      .s_inc    (s_inc),
      .we3      (we3),
      .wez      (wez),
      .pop      (pop),
      .push     (push),
      .s_stack  (s_stack),
      .we4      (we4),
      .we_out   (we_out),
      .s_inm    (s_inm),
      .s_in     (s_in),
      .s_out    (s_out),
      .op_alu   (op_alu),
      .s_vec    (s_vec),
      .vec_addr (vec_addr),
      .int_ack  (int_ack),
      .ie       (ie)
   );

   always #5 clk = ~clk;

   wire [17:0] ctl = {s_inc, we3, wez, pop, push, s_stack, we4, we_out,
                      s_inm, s_in, s_out, op_alu, s_vec};
   wire [30:0] obs = {ctl, int_ack, vec_addr, ie};

   // Reference model: ie flag, pending set, previous intr level, entry phase, served id.
   bit         m_ie;
   bit [1:0]   m_pend, m_prev;
   int         m_phase, m_id;
   logic [30:0] exp_obs;

   function automatic logic [17:0] ref_decode(input logic [5:0] op, input logic [1:0] io,
                                              input logic zz);
      logic inc, w3, wz, pp, ps, ss, w4, wo;
      logic [1:0] sinm, sin, sout;
      logic [2:0] alu;
      {inc, w3, wz, pp, ps, ss, w4, wo} = 8'b1000_0000;
      sinm = 2'd0; sin = 2'd0; sout = 2'd0; alu = 3'd0;
      if (op[5] == 1'b0) begin
         w3 = 1; wz = 1; alu = op[4:2];
      end else if (op[5:2] == 4'b1000) begin
         w3 = 1; sinm = 2'd1;
      end else if (op[5:2] == 4'b1110) begin
         w4 = 1;
      end else if (op[5:2] == 4'b1111) begin
         w3 = 1; sinm = 2'd2;
      end else begin
         case (op)
            6'b100100: inc = 0;
            6'b100101: inc = ~zz;
            6'b100110: inc = zz;
            6'b101000, 6'b101101: begin inc = 0; pp = 1; ss = 1; end
            6'b101001: ps = 1;
            6'b101010: begin w3 = 1; sinm = 2'd3; sin = io; end
            6'b101011: wo = 1;
            6'b101100: begin wo = 1; sout = 2'd1; end
            default: ;
         endcase
      end
      return {inc, w3, wz, pp, ps, ss, w4, wo, sinm, sin, sout, alu, 1'b0};
   endfunction

   function automatic int lowest(input bit [1:0] p);
      for (int i = 0; i < 2; i++) if (p[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_ie = 0; m_pend = 0; m_prev = 0; m_phase = 0; m_id = 0;
   endtask

   // Drive inputs and compute expected outputs for this cycle; leaves time 2 units later.
   task automatic apply(input logic [5:0] opc, input logic [1:0] io, input logic zz,
                        input logic [1:0] iv);
      logic [17:0] c;
      logic [1:0]  a;
      opcode = opc; io_sel = io; z = zz; intr = iv;
      a = 2'b00;
      if (m_phase == 1)      c = 18'h02000;
      else if (m_phase == 2) begin c = 18'h00001; a = 2'b01 << m_id; end
      else if (m_ie && m_pend != 0) c = 18'h0;
      else c = ref_decode(opc, io, zz);
      exp_obs = {c, a, 10'(1008 + 4 * m_id), m_ie};
      #2;
   endtask

   task automatic tick();
      bit [1:0] rise;
      @(posedge clk);
      rise = intr & ~m_prev;
      m_prev = intr;
      if (m_phase == 0) begin
         if (m_ie && m_pend != 0) begin
            m_id = lowest(m_pend); m_ie = 0; m_phase = 1;
         end else if (opcode == 6'b101101 || opcode == 6'b101110) m_ie = 1;
         else if (opcode == 6'b101111) m_ie = 0;
      end else if (m_phase == 1) m_phase = 2;
      else begin
         m_pend[m_id] = 0; m_phase = 0;
      end
      m_pend = m_pend | rise;
      #1;
   endtask

   task automatic test_reset();
      apply(6'b100111, 2'b00, 1'b0, 2'b00);
      n_checks++;
      if (obs !== {18'h20000, 2'b00, 10'd1008, 1'b0}) begin
         n_fail++; $display("FAIL reset_state obs=%h required=%h", obs, {18'h20000, 2'b00, 10'd1008, 1'b0});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_decode();
      for (int i = 0; i < 64; i++) begin
         apply(6'($urandom), 2'($urandom), 1'($urandom), 2'b00);
         n_checks++;
         if (obs !== exp_obs) begin
            n_fail++; $display("FAIL decode op=%b obs=%h required=%h", opcode, obs, exp_obs);
         end
         tick();
      end
   endtask

   task automatic test_jz_nop();
      logic [5:0]  ops [5] = '{6'b100101, 6'b100101, 6'b100110, 6'b100111, 6'b101110};
      logic        zs  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [17:0] ec  [5] = '{18'h00000, 18'h20000, 18'h20000, 18'h20000, 18'h20000};
      for (int i = 0; i < 5; i++) begin
         apply(ops[i], 2'b00, zs[i], 2'b00);
         n_checks++;
         if (ctl !== ec[i] || obs !== exp_obs) begin
            n_fail++; $display("FAIL jz_nop op=%b z=%b ctl=%h required=%h", ops[i], zs[i], ctl, ec[i]);
         end
         tick();
      end
   endtask

   task automatic test_entry();
      logic [1:0]  iv [4] = '{2'b10, 2'b00, 2'b00, 2'b00};
      logic [30:0] eo [4] = '{{18'h38002, 2'b00, 10'd1008, 1'b1}, {18'h00000, 2'b00, 10'd1008, 1'b1},
                              {18'h02000, 2'b00, 10'd1012, 1'b0}, {18'h00001, 2'b10, 10'd1012, 1'b0}};
      apply(6'b101110, 2'b00, 1'b0, 2'b00);
      tick();
      for (int i = 0; i < 4; i++) begin
         apply(6'b000100, 2'b00, 1'b0, iv[i]);
         n_checks++;
         if (obs !== eo[i] || obs !== exp_obs) begin
            n_fail++; $display("FAIL entry cycle=%0d obs=%h required=%h", i, obs, eo[i]);
         end
         tick();
      end
   endtask

   task automatic test_priority();
      logic [5:0] ops [9] = '{6'b101110, 6'b000000, 6'b100111, 6'b100111, 6'b100111,
                              6'b101101, 6'b100111, 6'b100111, 6'b100111};
      logic [1:0] iv  [9] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      for (int i = 0; i < 9; i++) begin
         apply(ops[i], 2'b00, 1'b0, iv[i]);
         n_checks++;
         if (obs !== exp_obs) begin
            n_fail++; $display("FAIL priority cycle=%0d obs=%h required=%h", i, obs, exp_obs);
         end
         if (i == 4 || i == 8) begin
            n_checks++;
            if (int_ack !== ((i == 4) ? 2'b01 : 2'b10) || vec_addr !== ((i == 4) ? 10'd1008 : 10'd1012)) begin
               n_fail++; $display("FAIL priority_order cycle=%0d ack=%b vec=%0d", i, int_ack, vec_addr);
            end
         end
         tick();
      end
   endtask

   task automatic test_masked();
      apply(6'b101111, 2'b00, 1'b0, 2'b00); tick();
      apply(6'b100111, 2'b00, 1'b0, 2'b01); tick();
      for (int i = 0; i < 5; i++) begin
         apply(6'b001000, 2'b00, 1'b0, 2'b00);
         n_checks++;
         if (s_vec !== 1'b0 || push !== 1'b0 || obs !== exp_obs) begin
            n_fail++; $display("FAIL masked cycle=%0d obs=%h required=%h", i, obs, exp_obs);
         end
         tick();
      end
      apply(6'b101110, 2'b00, 1'b0, 2'b00);
      n_checks++;
      if (s_inc !== 1'b1 || obs !== exp_obs) begin
         n_fail++; $display("FAIL masked_ei obs=%h required=%h", obs, exp_obs);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         apply(6'b000000, 2'b00, 1'b0, 2'b00);
         n_checks++;
         if (obs !== exp_obs || (i == 0 && s_inc !== 1'b0) || (i == 2 && int_ack !== 2'b01)) begin
            n_fail++; $display("FAIL masked_entry cycle=%0d obs=%h required=%h", i, obs, exp_obs);
         end
         tick();
      end
   endtask

   task automatic test_held();
      int acks = 0;
      for (int i = 0; i < 24; i++) begin
         apply(6'b101110, 2'b00, 1'b0, (i < 20) ? 2'b01 : 2'b00);
         if (int_ack[0] === 1'b1) acks++;
         n_checks++;
         if (obs !== exp_obs) begin
            n_fail++; $display("FAIL held cycle=%0d obs=%h required=%h", i, obs, exp_obs);
         end
         tick();
      end
      n_checks++;
      if (acks !== 1) begin
         n_fail++; $display("FAIL held_single_ack got=%0d required=1", acks);
      end
   endtask

   task automatic test_reset_mid();
      apply(6'b101110, 2'b00, 1'b0, 2'b00); tick();
      apply(6'b100111, 2'b00, 1'b0, 2'b01); tick();
      apply(6'b100111, 2'b00, 1'b0, 2'b00); tick();
      apply(6'b100111, 2'b00, 1'b0, 2'b00);
      n_checks++;
      if (push !== 1'b1 || obs !== exp_obs) begin
         n_fail++; $display("FAIL reset_mid_push obs=%h required=%h", obs, exp_obs);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (obs !== {18'h20000, 2'b00, 10'd1008, 1'b0}) begin
         n_fail++; $display("FAIL reset_mid_async obs=%h required=%h", obs, {18'h20000, 2'b00, 10'd1008, 1'b0});
      end
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      apply(6'b101110, 2'b00, 1'b0, 2'b00); tick();
      for (int i = 0; i < 4; i++) begin
         apply(6'b100111, 2'b00, 1'b0, 2'b00);
         n_checks++;
         if (s_inc !== 1'b1 || s_vec !== 1'b0 || obs !== exp_obs) begin
            n_fail++; $display("FAIL reset_mid_pending cycle=%0d obs=%h required=%h", i, obs, exp_obs);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [5:0] op;
      int r;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         op = (r == 0) ? 6'b101101 : (r == 1) ? 6'b101110 : (r == 2) ? 6'b101111 : 6'($urandom);
         apply(op, 2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
         n_checks++;
         if (obs !== exp_obs) begin
            n_fail++; $display("FAIL random cycle=%0d op=%b intr=%b obs=%h required=%h",
                               i, op, intr, obs, exp_obs);
         end
         tick();
      end
   endtask

   initial begin
      reset = 1'b1; opcode = 6'b100111; io_sel = 2'b00; z = 1'b0; intr = 2'b00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_decode();
      test_jz_nop();
      test_entry();
      test_priority();
      test_masked();
      test_held();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uc_int.md
Name: uc_int

Overview:
- Control unit for the single-cycle CPU, successor to the combinational decoder.
- Adds a sequential interrupt engine:
  - NINT parametrised interrupt lines with rising-edge latching and fixed priority.
  - Global interrupt-enable flag.
  - Three-state entry FSM that pushes the return PC and vectors to a handler.
  - EI/DI/RETI instructions.
- Sits between instruction memory (opcode field) and datapath/stack/IO control inputs.

Parameters:
- NINT, 2, number of interrupt lines (1..8).
- PCW, 10, program-counter width; width of vec_addr.
- VEC_BASE, 1008, address of vector 0.
- VEC_STRIDE, 4, address distance between consecutive vectors.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction bits [15:10].
- io_sel  in  2  instruction bits [9:8] (IN port select).
- z  in  1  ALU zero flag.
- intr  in  NINT  interrupt request lines, level; rising edge = request.
- s_inc, we3, wez, pop, push, s_stack, we4, we_out  out  1  datapath controls, same meaning as the current decoder.
- s_inm, s_in, s_out  out  2  datapath mux selects.
- op_alu  out  3  ALU operation.
- s_vec  out  1  PC loads vec_addr.
- vec_addr  out  PCW  handler address = VEC_BASE + id*VEC_STRIDE (modulo 2^PCW).
- int_ack  out  NINT  one-hot, one-cycle acknowledge.
- ie  out  1  global interrupt enable (registered).

Behaviour:
- Reset (async, any state): FSM=RUN, ie=0, pending=0, edge-history=0, latched id=0.
- Combinational outputs in RUN after reset follow opcode decode. Every output has an explicit default of 0 for every opcode (no latches).
- Decode in RUN, no interrupt taken; encodings unchanged from the current decoder:
  - 0zzzzz ALU: s_inc=1, we3=1, wez=1, op_alu=opcode[4:2].
  - 1000zz LOADI: s_inc=1, we3=1, s_inm=01.
  - 100100 JMP: s_inc=0.
  - 100101 JZ: s_inc=~z.
  - 100110 JNZ: s_inc=z.
  - 101000 RET: s_inc=0, pop=1, s_stack=1.
  - 101001 CALL: s_inc=1, push=1.
  - 101010 IN: s_inc=1, we3=1, s_inm=11, s_in=io_sel.
  - 101011 OUT REG: s_inc=1, we_out=1, s_out=00.
  - 101100 OUT INM: s_inc=1, we_out=1, s_out=01.
  - 1110zz STORE: s_inc=1, we4=1.
  - 1111zz LOAD: s_inc=1, we3=1, s_inm=10.
  - Others: s_inc=1, all else 0 (NOP).
- New opcodes:
  - 101101 RETI: as RET, plus ie<=1 at cycle end.
  - 101110 EI: s_inc=1, ie<=1.
  - 101111 DI: s_inc=1, ie<=0.
- Edge detection:
  - Registered intr_q per line; rise = intr & ~intr_q.
  - On each clock, pending[i] <= pending[i] | rise[i]; pending is cleared only by acknowledge or reset.
  - A line held high produces exactly one request.
- take = (state==RUN) & ie & |pending. The highest priority pending line (lowest index) is selected.
- FSM:
  - RUN, take=1:
    - Current instruction squashed: all write enables, push, pop, we_out = 0; s_inc=0 (PC holds).
    - Latch id; ie<=0; next INT_PUSH.
  - INT_PUSH: push=1, s_inc=0, all else 0. Stack receives the PC of the squashed instruction. Next INT_VEC.
  - INT_VEC: s_vec=1, s_inc=0, int_ack[id]=1, pending[id]<=0. Next RUN.
- Precedence and boundaries:
  - EI executing with pending set: take is evaluated on the current ie, so the interrupt is taken on the following instruction.
  - DI and take in the same cycle: take wins; DI is squashed.
  - RETI with pending set: next RUN cycle takes it.
  - A new edge on a line during INT_PUSH/INT_VEC is latched. If it hits the line being acked in INT_VEC, set wins over clear (pending stays 1).
  - Lower-priority pending lines are retained.
- Latency (no synchroniser): intr rises before edge k → pending=1 after edge k → squash cycle k..k+1 → INT_PUSH → INT_VEC → first handler instruction 3 cycles after pending.

Optional Feature:
- INTR_SYNC_EN defined: each intr line passes a 2-flop synchroniser (reset to 0) before edge detection; request latency +2 cycles.
- Undefined: intr used directly; intr is already synchronous to clk.

Decomposition:
- Package uc_pkg:
  - opcode localparams (OP_RETI=6'b101101, OP_EI, OP_DI, ...).
  - FSM state enum {RUN, INT_PUSH, INT_VEC}.
  - s_inm/s_out select constants.
- Sub-module int_prio (pending vector → valid, id, one-hot); purely combinational, NINT-parametrised.

Test Plan:
- Reset mid INT_PUSH → state RUN, ie=0, pending=0, push=0 immediately (asynchronous).
- EI, then intr[1] pulse during ALU op at PC=5 → squash (we3=0), push cycle, s_vec=1, vec_addr=1012, int_ack=2'b10, ie=0.
- intr[0] and intr[1] rise same cycle, ie=1 → id 0 served first (vec 1008). After RETI, id 1 served (vec 1012).
- ie=0, intr[0] pulses → pending held, no entry; EI → entry on next instruction.
- intr[0] held high 20 cycles → exactly one int_ack pulse.
- JZ with z=1 → s_inc=0; z=0 → s_inc=1. Undefined opcode 101111 absent from NOP set; check 6'b100111 → NOP outputs.
